// File: rtl/sa_pkg.sv
// Types and defaults shared by the psum accumulator and the downstream writeback stage.
package sa_pkg;

  localparam int unsigned ACC_WIDTH_DEFAULT = 40;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } acc_state_t;

endpackage

// File: rtl/psum_acc_buffer.sv
// Flop register file of accumulator rows: one overwrite/accumulate write port,
// one asynchronous read port. Contents are intentionally not reset.
module psum_acc_buffer #(
  parameter int unsigned ACC_WIDTH   = 40,
  parameter int unsigned ARRAY_WIDTH = 4,
  parameter int unsigned DEPTH       = 16,
  localparam int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        wr_en,
  input  logic                        wr_acc,
  input  logic [ADDR_WIDTH-1:0]       wr_addr,
  input  logic signed [ACC_WIDTH-1:0] wr_data [ARRAY_WIDTH],
  input  logic [ADDR_WIDTH-1:0]       rd_addr,
  output logic signed [ACC_WIDTH-1:0] rd_data [ARRAY_WIDTH]
);

  logic signed [ACC_WIDTH-1:0] mem [DEPTH][ARRAY_WIDTH];

  // First tile overwrites so stale rows from a previous job never leak in.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int l = 0; l < ARRAY_WIDTH; l++) begin
        mem[wr_addr][l] <= wr_acc ? (mem[wr_addr][l] + wr_data[l]) : wr_data[l];
      end
    end
  end

  always_comb begin
    for (int l = 0; l < ARRAY_WIDTH; l++) begin
      rd_data[l] = mem[rd_addr][l];
    end
  end

endmodule

// File: rtl/psum_accumulator.sv
// Accumulates systolic-array psum rows across K-tiles in a local buffer,
// then drains the summed rows over a valid/ready stream.
module psum_accumulator
  import sa_pkg::*;
#(
  parameter int unsigned PSUM_WIDTH  = 32,
  parameter int unsigned ACC_WIDTH   = ACC_WIDTH_DEFAULT,
  parameter int unsigned ARRAY_WIDTH = 4,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned TILE_WIDTH  = 8,
  localparam int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [TILE_WIDTH-1:0]        num_tiles,
  input  logic [ADDR_WIDTH:0]          rows,
  input  logic                         psum_valid,
  input  logic signed [PSUM_WIDTH-1:0] psum_in [ARRAY_WIDTH],
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [ACC_WIDTH-1:0]  out_data [ARRAY_WIDTH],
  output logic                         out_last,
  output logic                         busy,
  output logic                         done,
  output logic                         protocol_err
);

  localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;

  acc_state_t state, next_state;

  logic [ADDR_WIDTH-1:0] row_ptr, row_ptr_nxt;
  logic [ADDR_WIDTH-1:0] rd_ptr, rd_ptr_nxt;
  logic [TILE_WIDTH-1:0] tile_cnt, tile_cnt_nxt;
  logic [CNT_WIDTH-1:0]  rows_q;
  logic [TILE_WIDTH-1:0] tiles_q;

  logic [CNT_WIDTH-1:0]  rows_in_c;
  logic [TILE_WIDTH-1:0] tiles_in_c;
  logic [CNT_WIDTH-1:0]  rows_last;
  logic [TILE_WIDTH-1:0] tiles_last;

  logic start_ok, acc_wr, row_last, tile_last, drain_fire, rd_last;
  logic out_valid_d, out_last_d, busy_d, done_d, protocol_err_d;

  logic signed [ACC_WIDTH-1:0] wr_data [ARRAY_WIDTH];
  logic signed [ACC_WIDTH-1:0] rd_data [ARRAY_WIDTH];

  // Command sanitising: zero tiles means one, out-of-range rows means a full buffer.
  assign tiles_in_c = (num_tiles == '0) ? TILE_WIDTH'(1) : num_tiles;
  assign rows_in_c  = ((rows == '0) || (rows > CNT_WIDTH'(DEPTH))) ? CNT_WIDTH'(DEPTH) : rows;

  assign rows_last  = rows_q - CNT_WIDTH'(1);
  assign tiles_last = tiles_q - TILE_WIDTH'(1);

  assign start_ok   = (state == IDLE) && start;
  assign acc_wr     = (state == ACCUM) && psum_valid;
  assign row_last   = ({1'b0, row_ptr} == rows_last);
  assign tile_last  = (tile_cnt == tiles_last);
  assign drain_fire = (state == DRAIN) && out_valid && out_ready;
  assign rd_last    = ({1'b0, rd_ptr} == rows_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (start) next_state = ACCUM;
      ACCUM:   if (acc_wr && row_last && tile_last) next_state = DRAIN;
      DRAIN:   if (drain_fire && rd_last) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Registered outputs are computed from the next state so they align with it.
  always_comb begin
    busy_d         = (next_state != IDLE);
    out_valid_d    = (next_state == DRAIN);
    out_last_d     = (next_state == DRAIN) && ({1'b0, rd_ptr_nxt} == rows_last);
    done_d         = drain_fire && rd_last;
    protocol_err_d = protocol_err;
    if (start_ok)                             protocol_err_d = 1'b0;
    else if (psum_valid && (state != ACCUM))  protocol_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      out_valid    <= out_valid_d;
      out_last     <= out_last_d;
      busy         <= busy_d;
      done         <= done_d;
      protocol_err <= protocol_err_d;
    end
  end

  // Pointer next-values: write row/tile walk in ACCUM, read walk in DRAIN.
  always_comb begin
    row_ptr_nxt  = row_ptr;
    tile_cnt_nxt = tile_cnt;
    rd_ptr_nxt   = rd_ptr;
    if (start_ok) begin
      row_ptr_nxt  = '0;
      tile_cnt_nxt = '0;
      rd_ptr_nxt   = '0;
    end else if (acc_wr) begin
      if (row_last) begin
        row_ptr_nxt  = '0;
        tile_cnt_nxt = tile_cnt + TILE_WIDTH'(1);
        if (tile_last) rd_ptr_nxt = '0;
      end else begin
        row_ptr_nxt = row_ptr + ADDR_WIDTH'(1);
      end
    end else if (drain_fire) begin
      rd_ptr_nxt = rd_last ? '0 : (rd_ptr + ADDR_WIDTH'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_ptr  <= '0;
      tile_cnt <= '0;
      rd_ptr   <= '0;
      rows_q   <= CNT_WIDTH'(DEPTH);
      tiles_q  <= TILE_WIDTH'(1);
    end else begin
      row_ptr  <= row_ptr_nxt;
      tile_cnt <= tile_cnt_nxt;
      rd_ptr   <= rd_ptr_nxt;
      if (start_ok) begin
        rows_q  <= rows_in_c;
        tiles_q <= tiles_in_c;
      end
    end
  end

  always_comb begin
    for (int l = 0; l < ARRAY_WIDTH; l++) begin
      wr_data[l] = ACC_WIDTH'(psum_in[l]);
    end
  end

  psum_acc_buffer #(
    .ACC_WIDTH   (ACC_WIDTH),
    .ARRAY_WIDTH (ARRAY_WIDTH),
    .DEPTH       (DEPTH)
  ) u_buffer (
    .clk     (clk),
    .wr_en   (acc_wr),
    .wr_acc  (tile_cnt != '0),
    .wr_addr (row_ptr),
    .wr_data (wr_data),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  // Buffer is not reset, so the stream is forced to zero outside DRAIN.
  always_comb begin
    for (int l = 0; l < ARRAY_WIDTH; l++) begin
      out_data[l] = out_valid ? rd_data[l] : '0;
    end
  end

endmodule

// File: tb/tb_psum_accumulator.sv
// Scoreboard bench for psum_accumulator: jobs push expected beats computed by summing
// tiles per row; a negedge monitor pops and compares every accepted output beat.
module tb_psum_accumulator;

  localparam int unsigned PW    = 32;
  localparam int unsigned AW    = 40;
  localparam int unsigned LANES = 4;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned TW    = 8;
  localparam int unsigned ADW   = 4;

  typedef logic [LANES-1:0][PW-1:0] prow_t;
  typedef struct packed {
    logic                     last;
    logic [LANES-1:0][AW-1:0] d;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n, start, psum_valid;
  logic out_ready = 1'b1;
  logic out_valid, out_last, busy, done, protocol_err;
  logic [TW-1:0] num_tiles;
  logic [ADW:0]  rows;
  logic signed [PW-1:0] psum_in  [LANES];
  logic signed [AW-1:0] out_data [LANES];

  int n_cmp = 0, n_err = 0;
  int done_cnt = 0, hs_cnt = 0, hs_base = 0, hold_left = 0;
  int ready_mode = 0, stall_min = 0, stall_max = 0;

  prow_t stim_q[$];
  beat_t exp_q[$];
  beat_t mon_e;
  bit prev_stall = 1'b0;
  logic [LANES-1:0][AW-1:0] prev_d;
  logic prev_last;

  psum_accumulator #(
    .PSUM_WIDTH (PW), .ACC_WIDTH (AW), .ARRAY_WIDTH (LANES), .DEPTH (DEPTH), .TILE_WIDTH (TW)
  ) dut (
    .clk (clk), .rst_n (rst_n), .start (start), .num_tiles (num_tiles), .rows (rows),
    .psum_valid (psum_valid), .psum_in (psum_in), .out_valid (out_valid), .out_ready (out_ready),
    .out_data (out_data), .out_last (out_last), .busy (busy), .done (done),
    .protocol_err (protocol_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic prow_t mk(input int a, input int b, input int c, input int d);
    prow_t p;
    p[0] = PW'(a); p[1] = PW'(b); p[2] = PW'(c); p[3] = PW'(d);
    return p;
  endfunction

  // Downstream ready: always, random, hold-after-first-beat, or never.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = ($urandom_range(0, 99) < 60);
      2: if ((hs_cnt == hs_base + 1) && (hold_left > 0)) begin
           out_ready = 1'b0;
           hold_left--;
         end else begin
           out_ready = 1'b1;
         end
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor: stability under backpressure, then scoreboard compare on each handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (prev_stall) begin
        check("hold_valid", longint'(out_valid), 1);
        for (int l = 0; l < LANES; l++) check("hold_data", out_data[l], $signed(prev_d[l]));
        check("hold_last", longint'(out_last), longint'(prev_last));
      end
      if (out_valid && out_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          for (int l = 0; l < LANES; l++)
            check($sformatf("beat_lane%0d", l), out_data[l], $signed(mon_e.d[l]));
          check("beat_last", longint'(out_last), longint'(mon_e.last));
        end
      end
      prev_stall = out_valid && !out_ready;
      for (int l = 0; l < LANES; l++) prev_d[l] = out_data[l];
      prev_last = out_last;
    end
  end

  // Runs one job: model = per-row sum over all tiles, starting from zero each job.
  task automatic run_job(input int r, input int t, input bit v_with_start, input bit rnd,
                         input bit no_wait);
    int er, et, d0, cyc, gap;
    longint acc [DEPTH][LANES];
    longint tmp;
    prow_t row;
    beat_t e;
    er = ((r == 0) || (r > int'(DEPTH))) ? int'(DEPTH) : r;
    et = (t == 0) ? 1 : t;
    if (rnd) begin
      stim_q.delete();
      for (int k = 0; k < er * et; k++) begin
        for (int l = 0; l < LANES; l++) row[l] = $urandom;
        stim_q.push_back(row);
      end
    end
    for (int k = 0; k < er; k++)
      for (int l = 0; l < LANES; l++) acc[k][l] = 0;
    for (int k = 0; k < er * et; k++)
      for (int l = 0; l < LANES; l++) acc[k % er][l] += longint'($signed(stim_q[k][l]));
    for (int k = 0; k < er; k++) begin
      for (int l = 0; l < LANES; l++) begin
        tmp = acc[k][l];
        e.d[l] = AW'(tmp);
      end
      e.last = (k == er - 1);
      exp_q.push_back(e);
    end
    d0 = done_cnt;

    @(posedge clk); #1;
    start = 1'b1; num_tiles = TW'(t); rows = (ADW + 1)'(r);
    if (v_with_start) begin
      psum_valid = 1'b1;
      for (int l = 0; l < LANES; l++) psum_in[l] = 9;
    end
    @(posedge clk); #1;
    start = 1'b0; psum_valid = 1'b0;
    @(negedge clk);
    check("busy_after_start", longint'(busy), 1);
    check("perr_after_start", longint'(protocol_err), 0);
    @(posedge clk); #1;

    while (stim_q.size() > 0) begin
      row = stim_q.pop_front();
      psum_valid = 1'b1;
      for (int l = 0; l < LANES; l++) psum_in[l] = row[l];
      if (rnd && ($urandom_range(0, 7) == 0)) begin
        start = 1'b1; num_tiles = TW'($urandom); rows = (ADW + 1)'($urandom);
      end
      @(posedge clk); #1;
      psum_valid = 1'b0; start = 1'b0;
      gap = $urandom_range(stall_max, stall_min);
      repeat (gap) begin @(posedge clk); #1; end
    end
    if (no_wait) return;

    cyc = 0;
    while (!done && cyc < 3000) begin @(negedge clk); cyc++; end
    check("done_in_time", longint'(cyc < 3000), 1);
    repeat (3) @(negedge clk);
    check("done_pulses", done_cnt - d0, 1);
    check("beats_left", exp_q.size(), 0);
    check("idle_after_job", longint'(busy), 0);
  endtask

  initial begin
    int cyc;
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    rst_n = 1'b0; start = 1'b0; psum_valid = 1'b0; num_tiles = '0; rows = '0;
    for (int l = 0; l < LANES; l++) psum_in[l] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_out_last", longint'(out_last), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_done", longint'(done), 0);
    check("rst_perr", longint'(protocol_err), 0);
    check("rst_out_data", out_data[0], 0);
    @(posedge clk); #1; rst_n = 1'b1;

    // Basic two-row single tile.
    stim_q = '{mk(1, 2, 3, 4), mk(5, 6, 7, 8)};
    run_job(2, 1, 0, 0, 0);

    // Three tiles of one row, one stall cycle between.
    stall_min = 1; stall_max = 1;
    stim_q = '{mk(10, -3, 0, 7), mk(10, -3, 0, 7), mk(10, -3, 0, 7)};
    run_job(1, 3, 0, 0, 0);
    stall_min = 0; stall_max = 0;

    // Backpressure for three cycles on beat 2.
    ready_mode = 2; hs_base = hs_cnt; hold_left = 3;
    run_job(3, 1, 0, 1, 0);
    check("backpressure_applied", hold_left, 0);
    ready_mode = 0;

    // Sign extension: two most-negative psums must reach -2^32.
    stim_q = '{mk(int'(32'h8000_0000), 1, -1, 0), mk(int'(32'h8000_0000), 1, -1, 0)};
    run_job(1, 2, 0, 0, 0);

    // psum in IDLE sets the sticky error and produces no beat.
    @(posedge clk); #1;
    psum_valid = 1'b1;
    for (int l = 0; l < LANES; l++) psum_in[l] = 9;
    @(posedge clk); #1; psum_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("perr_idle_psum", longint'(protocol_err), 1);
    check("idle_psum_busy", longint'(busy), 0);
    run_job(2, 2, 1, 1, 0);

    // psum in DRAIN, then reset mid-DRAIN.
    ready_mode = 3;
    run_job(4, 1, 0, 1, 1);
    cyc = 0;
    while (!out_valid && cyc < 100) begin @(negedge clk); cyc++; end
    check("drain_reached", longint'(out_valid), 1);
    @(posedge clk); #1;
    psum_valid = 1'b1;
    for (int l = 0; l < LANES; l++) psum_in[l] = 9;
    @(posedge clk); #1; psum_valid = 1'b0;
    @(negedge clk);
    check("perr_drain_psum", longint'(protocol_err), 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", longint'(out_valid), 0);
    check("mid_rst_busy", longint'(busy), 0);
    check("mid_rst_out_last", longint'(out_last), 0);
    check("mid_rst_perr", longint'(protocol_err), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    ready_mode = 0;
    stim_q = '{mk(4, 3, 2, 1)};
    run_job(1, 1, 0, 0, 0);

    // Clamping: rows 0 and rows > DEPTH become DEPTH, tiles 0 becomes 1.
    run_job(0, 0, 0, 1, 0);
    run_job(20, 1, 0, 1, 0);

    // Randomized jobs with stalls and random backpressure.
    ready_mode = 1; stall_min = 0; stall_max = 2;
    for (int j = 0; j < 8; j++) run_job($urandom_range(1, 17), $urandom_range(0, 4), 0, 1, 0);
    ready_mode = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/psum_accumulator.md
Name: psum_accumulator

Overview:
- Downstream of the input-stationary systolic array; consumes its unskewed psum_out vector, one row per cycle.
- Accumulates psum vectors across multiple K-tiles into an on-chip register buffer of DEPTH rows.
- When all tiles are done, drains the accumulated rows to the writeback path over a valid/ready stream.
- Lets the array process K larger than ARRAY_HEIGHT without off-chip partial-sum traffic.

Parameters:
- PSUM_WIDTH, 32: width of each incoming signed partial sum.
- ACC_WIDTH, 40: width of each signed accumulator entry; must be >= PSUM_WIDTH.
- ARRAY_WIDTH, 4: lanes per psum vector; matches the systolic array output vector.
- DEPTH, 16: maximum rows per tile held in the buffer.
- TILE_WIDTH, 8: width of the tile-count input.
- ADDR_WIDTH, $clog2(DEPTH): localparam, row pointer width.

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: single-cycle command; accepted only in IDLE.
- num_tiles, input, TILE_WIDTH: K-tiles to accumulate; sampled on start; 0 is treated as 1.
- rows, input, ADDR_WIDTH+1: rows per tile; sampled on start; 0 or >DEPTH is clamped to DEPTH.
- psum_valid, input, 1: psum_in holds a valid row this cycle.
- psum_in, input, ARRAY_WIDTH x PSUM_WIDTH signed (unpacked array): row from the systolic array.
- out_valid, output, 1: out_data valid.
- out_ready, input, 1: downstream accepts out_data.
- out_data, output, ARRAY_WIDTH x ACC_WIDTH signed (unpacked array): accumulated row.
- out_last, output, 1: high with the final drained row.
- busy, output, 1: high when not in IDLE.
- done, output, 1: one-cycle pulse after the final drain handshake.
- protocol_err, output, 1: sticky flag; psum_valid arrived outside ACCUM.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; row_ptr, tile_cnt, rd_ptr = 0.
  - out_valid, out_last, busy, done, protocol_err = 0; out_data = 0.
  - Buffer contents are not reset; they are don't-care.
- States: IDLE, ACCUM, DRAIN.
- IDLE:
  - start=1 latches num_tiles/rows (with the substitutions above), clears protocol_err, zeroes pointers, next state ACCUM.
- ACCUM: on each psum_valid cycle:
  - tile_cnt==0: buf[row_ptr] <= sext(psum_in), i.e. overwrite, so no stale data carries over.
  - tile_cnt>0: buf[row_ptr] <= buf[row_ptr] + sext(psum_in), per lane, two's-complement wrap at ACC_WIDTH (no saturation).
  - row_ptr increments; at rows-1 it wraps to 0 and tile_cnt increments.
  - The write of row rows-1 in tile num_tiles-1 moves to DRAIN with rd_ptr=0.
  - psum_valid low is a stall; state and pointers hold.
- DRAIN:
  - out_valid=1 from the first DRAIN cycle, i.e. the cycle after the final accumulate write.
  - out_data = buf[rd_ptr] (combinational read of the flop buffer); out_last = (rd_ptr==rows-1).
  - out_valid and out_ready high together advances rd_ptr.
  - While out_ready=0, out_data/out_last stay stable and out_valid stays high.
  - The handshake on the last row moves to IDLE; done pulses in the first IDLE cycle.
- Edge cases:
  - start while busy: ignored, with no effect on latched config.
  - psum_valid in IDLE or DRAIN: data dropped, buffer untouched, protocol_err set to 1 and held until the next accepted start.
  - psum_valid and start in the same IDLE cycle: start is accepted, psum is dropped, protocol_err ends at 0 (clear takes priority).
  - Reset mid-ACCUM or mid-DRAIN: immediate return to IDLE, outputs at reset values; the next job's first tile overwrites.
- Throughput:
  - One psum row per cycle in ACCUM.
  - One row per cycle in DRAIN when out_ready=1; drain takes exactly rows cycles with no backpressure.

Decomposition:
- Shared package sa_pkg:
  - typedef acc_state_t enum {IDLE, ACCUM, DRAIN}.
  - Default ACC_WIDTH constant, shared with the writeback stage.
- Sub-module psum_acc_buffer:
  - DEPTH x ARRAY_WIDTH x ACC_WIDTH flop register file.
  - One write port with overwrite/accumulate select; one asynchronous read port.
- The top level holds the FSM, pointers, handshake and error logic.

Test Plan:
- rows=2, num_tiles=1; psum {1,2,3,4} then {5,6,7,8}, out_ready=1 → two beats {1,2,3,4}, {5,6,7,8}; out_last on beat 2; done pulses once.
- rows=1, num_tiles=3; psum {10,-3,0,7} ×3 with one stall cycle between → single beat {30,-9,0,21}, out_last=1.
- rows=3, num_tiles=1; out_ready low 3 cycles at beat 2 → beat-2 data/out_last stable throughout, out_valid held; exactly 3 beats, no loss or duplicate.
- Sign/width: rows=1, num_tiles=2, lane0 = -2^31 twice → out_data[0] = -2^32 exactly (no wrap at 40 bits).
- psum_valid=1 with {9,9,9,9} in IDLE → protocol_err=1, no beats; next start clears it; the job completes normally with correct values.
- Assert rst_n low mid-DRAIN → out_valid, busy, out_last = 0 immediately; new job rows=1, num_tiles=1 with {4,3,2,1} drains {4,3,2,1} (no stale accumulation).
